astro_game_ctrl: RTL and testbench

Game sequencer for the AstroBarrier VGA game. Owns the game state machine (idle, level 1, level 2, done), the player, target and bullet positions, hit detection and scoring. Its registered positions feed the VGA pixel-compare logic; its state and score feed the LED and SSD logic. All motion advances on a one-cycle `tick` strobe derived from the clock divider.

---
 rtl/astro_game_ctrl_if.sv | 30 +++
 rtl/astro_game_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_astro_game_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/astro_game_ctrl_if.sv
// astro_game_ctrl_if: control inputs and sprite/score outputs of the game sequencer.
// master drives buttons/strobes, slave is the sequencer itself.
interface astro_game_ctrl_if;
    logic       tick;
    logic       start;
    logic       btn_left;
    logic       btn_right;
    logic       btn_fire;
    logic [1:0] state;
    logic [9:0] player_x;
    logic [9:0] target_x;
    logic [9:0] bullet_x;
    logic [9:0] bullet_y;
    logic       bullet_active;
    logic [3:0] score;
    logic       hit;
    logic [7:0] time_left;

    modport master (
        output tick, start, btn_left, btn_right, btn_fire,
        input  state, player_x, target_x, bullet_x, bullet_y,
        input  bullet_active, score, hit, time_left
    );

    modport slave (
        input  tick, start, btn_left, btn_right, btn_fire,
        output state, player_x, target_x, bullet_x, bullet_y,
        output bullet_active, score, hit, time_left
    );
endinterface

// File: rtl/astro_game_ctrl.sv
// astro_game_ctrl: AstroBarrier sequencer - levels, sprite motion, hits, score.
// Define GAME_TIMER_EN to add a per-level tick budget that ends the game at zero.
module astro_game_ctrl #(
    parameter int PLAYER_MIN   = 10,
    parameter int PLAYER_MAX   = 630,
    parameter int TGT_MIN      = 202,
    parameter int TGT_MAX      = 398,
    parameter int BULLET_START = 448,
    parameter int BULLET_STEP  = 8,
    parameter int TGT_Y_TOP    = 256,
    parameter int TGT_Y_BOT    = 319,
    parameter int HALF_W       = 10,
    parameter int LEVEL_HITS   = 5,
    parameter int TIMER_TICKS  = 255
) (
    input logic              clk,
    input logic              reset_n,
    astro_game_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        QI      = 2'b00,
        QGAME_1 = 2'b01,
        QGAME_2 = 2'b10,
        QDONE   = 2'b11
    } state_t;

    localparam logic [10:0] P_MIN   = 11'(PLAYER_MIN);
    localparam logic [10:0] P_MAX   = 11'(PLAYER_MAX);
    localparam logic [10:0] T_MIN   = 11'(TGT_MIN);
    localparam logic [10:0] T_MAX   = 11'(TGT_MAX);
    localparam logic [10:0] Y_TOP   = 11'(TGT_Y_TOP);
    localparam logic [10:0] Y_BOT   = 11'(TGT_Y_BOT);
    localparam logic [10:0] B_STEP  = 11'(BULLET_STEP);
    localparam logic [10:0] HIT_W   = 11'(2 * HALF_W);
    localparam logic [9:0]  B_START = 10'(BULLET_START);
    localparam logic [9:0]  X_START = 10'd400;
    localparam logic [9:0]  T_START = 10'd200;
    localparam logic [3:0]  LVL     = 4'(LEVEL_HITS);
`ifdef GAME_TIMER_EN
    localparam logic [7:0]  TL_LOAD = 8'(TIMER_TICKS);
`else
    localparam logic [7:0]  TL_LOAD = 8'(TIMER_TICKS) & 8'h00;
`endif

    state_t     state_q, state_d;
    logic [9:0] px_q, px_d, tx_q, tx_d;
    logic [9:0] bx_q, bx_d, by_q, by_d;
    logic       tdir_q, tdir_d, ba_q, ba_d, hit_q, hit_d;
    logic [3:0] sc_q, sc_d;
    logic [7:0] tl_q, tl_d;

    logic [9:0]  step, p_up, p_dn, t_up, t_dn;
    logic [10:0] diff;
    logic [3:0]  sc_inc;
    logic        hit_now;

    // Wide compares keep saturation and |dx| free of wraparound.
    always_comb begin
        step = (state_q == QGAME_2) ? 10'd4 : 10'd2;
        p_up = ({1'b0, px_q} + 11'd2 > P_MAX) ? P_MAX[9:0] : px_q + 10'd2;
        p_dn = ({1'b0, px_q} < P_MIN + 11'd2) ? P_MIN[9:0] : px_q - 10'd2;
        t_up = tx_q + step;
        t_dn = tx_q - step;
        diff = (bx_q >= tx_q) ? {1'b0, bx_q - tx_q} : {1'b0, tx_q - bx_q};
        hit_now = ba_q && ({1'b0, by_q} >= Y_TOP)
                  && ({1'b0, by_q} <= Y_BOT) && (diff <= HIT_W);
        sc_inc = sc_q + 4'd1;
    end

    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        tx_d    = tx_q;
        tdir_d  = tdir_q;
        bx_d    = bx_q;
        by_d    = by_q;
        ba_d    = ba_q;
        sc_d    = sc_q;
        tl_d    = tl_q;
        hit_d   = 1'b0;
        unique case (state_q)
            QI: begin
                if (bus.start) begin
                    state_d = QGAME_1;
                    px_d    = X_START;
                    tx_d    = T_START;
                    tdir_d  = 1'b1;
                    sc_d    = 4'd0;
                    ba_d    = 1'b0;
                    tl_d    = TL_LOAD;
                end
            end
            QGAME_1, QGAME_2: begin
                if (bus.tick) begin
                    unique case (1'b1)
                        bus.btn_right && !bus.btn_left: px_d = p_up;
                        bus.btn_left && !bus.btn_right: px_d = p_dn;
                        default: px_d = px_q;
                    endcase
                    if (tdir_q) begin
                        if ({1'b0, t_up} >= T_MAX) begin
                            tx_d   = T_MAX[9:0];
                            tdir_d = 1'b0;
                        end else begin
                            tx_d = t_up;
                        end
                    end else begin
                        if ({1'b0, tx_q} <= T_MIN + {1'b0, step}) begin
                            tx_d   = T_MIN[9:0];
                            tdir_d = 1'b1;
                        end else begin
                            tx_d = t_dn;
                        end
                    end
                    if (!ba_q) begin
                        if (bus.btn_fire) begin
                            ba_d = 1'b1;
                            bx_d = px_q;
                            by_d = B_START;
                        end
                    end else if (hit_now) begin
                        ba_d  = 1'b0;
                        hit_d = 1'b1;
                        sc_d  = sc_inc;
                    end else if ({1'b0, by_q} < B_STEP) begin
                        ba_d = 1'b0;
                    end else begin
                        by_d = by_q - B_STEP[9:0];
                    end
`ifdef GAME_TIMER_EN
                    if (tl_q != 8'd0) tl_d = tl_q - 8'd1;
`endif
                    if (hit_now && state_q == QGAME_1 && sc_inc == LVL) begin
                        state_d = QGAME_2;
                        tx_d    = T_START;
                        tdir_d  = 1'b1;
                        ba_d    = 1'b0;
                        tl_d    = TL_LOAD;
                    end else if (hit_now && state_q == QGAME_2 && sc_inc == 4'd10) begin
                        state_d = QDONE;
                    end
`ifdef GAME_TIMER_EN
                    if (tl_q <= 8'd1) state_d = QDONE;
`endif
                end
            end
            QDONE: begin
                if (!bus.start) state_d = QI;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= QI;
            px_q    <= X_START;
            tx_q    <= T_START;
            tdir_q  <= 1'b1;
            bx_q    <= 10'd0;
            by_q    <= 10'd0;
            ba_q    <= 1'b0;
            sc_q    <= 4'd0;
            hit_q   <= 1'b0;
            tl_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            tx_q    <= tx_d;
            tdir_q  <= tdir_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            ba_q    <= ba_d;
            sc_q    <= sc_d;
            hit_q   <= hit_d;
            tl_q    <= tl_d;
        end
    end

    assign bus.state         = state_q;
    assign bus.player_x      = px_q;
    assign bus.target_x      = tx_q;
    assign bus.bullet_x      = bx_q;
    assign bus.bullet_y      = by_q;
    assign bus.bullet_active = ba_q;
    assign bus.score         = sc_q;
    assign bus.hit           = hit_q;
    assign bus.time_left     = tl_q;
endmodule

// File: tb/tb_astro_game_ctrl.sv
// tb_astro_game_ctrl: directed game scenarios with a queued expectation scoreboard.
// Probes and hit pulses are checked by a separate negedge monitor.
module tb_astro_game_ctrl;
`ifdef GAME_TIMER_EN
    localparam int TT = 20;
`else
    localparam int TT = 255;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    astro_game_ctrl_if bus();

    astro_game_ctrl #(.TIMER_TICKS(TT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef enum int {S_ST, S_PX, S_TX, S_BX, S_BY, S_BA, S_SC, S_HIT, S_TL} sel_e;
    typedef struct {string nm; sel_e sel; int val;} exp_t;
    typedef struct {int sc; int st;} hexp_t;

    exp_t  pq[$];
    hexp_t hq[$];
    exp_t  ex;
    hexp_t hx;
    int    n_chk = 0;
    int    n_fail = 0;
    logic  probe = 1'b0;
    logic  prev_hit = 1'b0;

    function automatic int actual(sel_e s);
        case (s)
            S_ST:  return int'(bus.state);
            S_PX:  return int'(bus.player_x);
            S_TX:  return int'(bus.target_x);
            S_BX:  return int'(bus.bullet_x);
            S_BY:  return int'(bus.bullet_y);
            S_BA:  return int'(bus.bullet_active);
            S_SC:  return int'(bus.score);
            S_HIT: return int'(bus.hit);
            S_TL:  return int'(bus.time_left);
            default: return -1;
        endcase
    endfunction

    task automatic check(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: hit pulses pop the hit queue, probe strobes drain the probe queue.
    always @(negedge clk) begin
        if (prev_hit) check("hit_width", int'(bus.hit), 0);
        if (bus.hit === 1'b1) begin
            if (hq.size() == 0) begin
                check("hit_unexpected", int'(bus.hit), 0);
            end else begin
                hx = hq.pop_front();
                check("hit_score", int'(bus.score), hx.sc);
                check("hit_state", int'(bus.state), hx.st);
            end
        end
        prev_hit <= (bus.hit === 1'b1);
        if (probe) begin
            while (pq.size() > 0) begin
                ex = pq.pop_front();
                check(ex.nm, actual(ex.sel), ex.val);
            end
        end
    end

    task automatic expect_v(string nm, sel_e s, int v);
        pq.push_back('{nm, s, v});
    endtask

    task automatic hit_exp(int sc, int st);
        hq.push_back('{sc, st});
    endtask

    task automatic sample();
        probe = 1'b1;
        @(posedge clk);
        #1;
        probe = 1'b0;
    endtask

    // Called at posedge+1; n consecutive tick cycles with the given buttons.
    task automatic run(int n, bit l, bit r, bit f);
        bus.btn_left  = l;
        bus.btn_right = r;
        bus.btn_fire  = f;
        bus.tick      = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        bus.tick      = 1'b0;
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        bus.btn_fire  = 1'b0;
    endtask

    task automatic reset_vals(string tag);
        expect_v({tag, "_state"}, S_ST, 0);
        expect_v({tag, "_px"}, S_PX, 400);
        expect_v({tag, "_tx"}, S_TX, 200);
        expect_v({tag, "_bx"}, S_BX, 0);
        expect_v({tag, "_by"}, S_BY, 0);
        expect_v({tag, "_ba"}, S_BA, 0);
        expect_v({tag, "_score"}, S_SC, 0);
        expect_v({tag, "_hit"}, S_HIT, 0);
        expect_v({tag, "_tl"}, S_TL, 0);
        sample();
    endtask

    // From fresh level-1 entry: player to 300, then one shot every 196 ticks
    // (one full target period) so each bullet meets the target at 300.
    task automatic play_l1();
        run(50, 1, 0, 0);
        expect_v("l1_px", S_PX, 300);
        expect_v("l1_tx", S_TX, 300);
        sample();
        run(80, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            hit_exp(k + 1, (k == 4) ? 2 : 1);
            run(1, 0, 0, 1);
            if (k == 0) begin
                expect_v("fire_bx", S_BX, 300);
                expect_v("fire_by", S_BY, 448);
                expect_v("fire_ba", S_BA, 1);
                sample();
            end
            run((k < 4) ? 195 : 18, 0, 0, 0);
        end
        expect_v("l2_entry_state", S_ST, 2);
        expect_v("l2_entry_tx", S_TX, 200);
        expect_v("l2_entry_score", S_SC, 5);
        expect_v("l2_entry_ba", S_BA, 0);
        sample();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.tick = 1'b0;
        bus.start = 1'b0;
        bus.btn_left = 1'b0;
        bus.btn_right = 1'b0;
        bus.btn_fire = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_vals("rst");
        reset_n = 1'b1;
        @(posedge clk);
        #1;
`ifdef GAME_TIMER_EN
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        expect_v("tmr_state", S_ST, 1);
        expect_v("tmr_load", S_TL, 20);
        sample();
        run(19, 0, 0, 0);
        expect_v("tmr_19_state", S_ST, 1);
        expect_v("tmr_19_tl", S_TL, 1);
        sample();
        run(1, 0, 0, 0);
        expect_v("tmr_done_state", S_ST, 3);
        expect_v("tmr_done_score", S_SC, 0);
        expect_v("tmr_done_tl", S_TL, 0);
        sample();
`else
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        expect_v("g1_state", S_ST, 1);
        expect_v("g1_px", S_PX, 400);
        expect_v("g1_tx", S_TX, 200);
        expect_v("g1_tl", S_TL, 0);
        sample();
        run(99, 0, 0, 0);
        expect_v("bounce_tx", S_TX, 398);
        expect_v("bounce_px", S_PX, 400);
        sample();
        run(1, 0, 0, 0);
        expect_v("bounce_back_tx", S_TX, 396);
        sample();
        run(200, 0, 1, 0);
        expect_v("clamp_max_px", S_PX, 630);
        expect_v("clamp_max_tx", S_TX, 388);
        sample();
        run(5, 1, 1, 0);
        expect_v("both_btn_px", S_PX, 630);
        expect_v("both_btn_tx", S_TX, 378);
        sample();
        run(320, 1, 0, 0);
        expect_v("clamp_min_px", S_PX, 10);
        expect_v("clamp_min_tx", S_TX, 274);
        sample();
        run(1, 0, 0, 1);
        expect_v("miss_bx", S_BX, 10);
        expect_v("miss_by", S_BY, 448);
        expect_v("miss_ba", S_BA, 1);
        sample();
        run(55, 0, 0, 0);
        expect_v("miss_by8", S_BY, 8);
        expect_v("miss_ba8", S_BA, 1);
        sample();
        run(1, 0, 0, 0);
        expect_v("miss_by0", S_BY, 0);
        expect_v("miss_ba0", S_BA, 1);
        sample();
        run(1, 0, 0, 0);
        expect_v("miss_clear_ba", S_BA, 0);
        expect_v("miss_clear_by", S_BY, 0);
        sample();
        run(2, 0, 0, 1);
        expect_v("refire_by", S_BY, 440);
        expect_v("refire_ba", S_BA, 1);
        expect_v("refire_score", S_SC, 0);
        sample();

        // Full game: start held high throughout, so it is ignored in play
        // and keeps QDONE from falling back to QI.
        reset_n = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        play_l1();
        hit_exp(6, 2);
        run(7, 0, 0, 0);
        run(1, 0, 0, 1);
        run(48, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            hit_exp(7 + k, (k == 3) ? 3 : 2);
            run(1, 0, 0, 1);
            run((k < 3) ? 97 : 18, 0, 0, 0);
        end
        expect_v("done_state", S_ST, 3);
        expect_v("done_score", S_SC, 10);
        expect_v("done_px", S_PX, 300);
        sample();
        run(3, 1, 0, 1);
        expect_v("done_hold_state", S_ST, 3);
        expect_v("done_hold_score", S_SC, 10);
        expect_v("done_hold_px", S_PX, 300);
        sample();
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        expect_v("back_to_idle", S_ST, 0);
        sample();

        // Second run into level 2, then reset with a bullet in flight.
        reset_n = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        play_l1();
        run(1, 0, 0, 1);
        run(3, 0, 0, 0);
        expect_v("flight_state", S_ST, 2);
        expect_v("flight_bx", S_BX, 300);
        expect_v("flight_by", S_BY, 424);
        expect_v("flight_ba", S_BA, 1);
        sample();
        bus.start = 1'b0;
        reset_n = 1'b0;
        reset_vals("async_rst");
        reset_n = 1'b1;
        @(posedge clk);
        #1;
`endif
        check("hits_outstanding", hq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
